// File: rtl/keypad_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner_pkg
// Purpose  : Shared keypad geometry, clock default and key-priority helpers.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_scanner_pkg;

  localparam int CLK_FREQ_HZ = 12_000_000;
  localparam int KEYPAD_COLS = 4;
  localparam int KEYPAD_ROWS = 4;
  localparam int KEYPAD_KEYS = KEYPAD_COLS * KEYPAD_ROWS;
  localparam int DB_CNT_W    = 3;

  // Index of the lowest set bit; lower index means lower row within a column.
  function automatic logic [3:0] lowest_key(input logic [KEYPAD_KEYS-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = KEYPAD_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = i[3:0];
    end
    return idx;
  endfunction

  function automatic logic multi_hot(input logic [KEYPAD_KEYS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < KEYPAD_KEYS; i++) begin
      if (v[i]) n++;
    end
    return (n > 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Per-key sample counter; flips the stable state after N mismatches.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_en,
  input  logic sample,
  output logic stable,
  output logic rise
);

  logic [DB_CNT_W-1:0] r_db_cnt;
  logic                r_stable;
  logic                w_mature;

  // The mismatch seen this sample would be the last one needed.
  assign w_mature = (r_db_cnt == DB_CNT_W'(DEBOUNCE_SCANS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt <= '0;
      r_stable <= 1'b0;
    end else if (sample_en) begin
      if (sample == r_stable) begin
        r_db_cnt <= '0;
      end else if (w_mature) begin
        r_stable <= ~r_stable;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_CNT_W'(1);
      end
    end
  end

  assign stable = r_stable;
  assign rise   = sample_en & sample & ~r_stable & w_mature;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : 4x4 column-scanned keypad with per-key debounce and press strobe.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int CLK_FREQ       = CLK_FREQ_HZ,
  parameter int SCAN_FREQ_HZ   = 1600,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [KEYPAD_ROWS-1:0] row_in,
  output logic [KEYPAD_COLS-1:0] col_drv,
  output logic [KEYPAD_KEYS-1:0] key_map,
  output logic                   key_valid,
  output logic [3:0]             key_code,
  output logic                   key_overrun
);

  localparam int SCAN_CNT_MAX = CLK_FREQ / SCAN_FREQ_HZ;
  localparam int CNT_W        = (SCAN_CNT_MAX > 1) ? $clog2(SCAN_CNT_MAX) : 1;

  logic [KEYPAD_ROWS-1:0] r_row_meta;
  logic [KEYPAD_ROWS-1:0] r_row_sync;
  logic [CNT_W-1:0]       r_scan_cnt;
  logic [1:0]             r_col_idx;
  logic                   w_sample_pt;
  logic [KEYPAD_KEYS-1:0] w_rise;
  logic                   r_key_valid;
  logic [3:0]             r_key_code;
  logic                   r_key_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_meta <= '0;
      r_row_sync <= '0;
    end else begin
      r_row_meta <= row_in;
      r_row_sync <= r_row_meta;
    end
  end

  // Sampling on the last cycle of a column gives the rows time to settle.
  assign w_sample_pt = (r_scan_cnt == CNT_W'(SCAN_CNT_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_col_idx  <= '0;
    end else if (w_sample_pt) begin
      r_scan_cnt <= '0;
      r_col_idx  <= r_col_idx + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + CNT_W'(1);
    end
  end

  assign col_drv = 4'b0001 << r_col_idx;

  for (genvar k = 0; k < KEYPAD_KEYS; k++) begin : g_keys
    key_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_key_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (w_sample_pt && (r_col_idx == 2'(k / KEYPAD_ROWS))),
      .sample    (r_row_sync[k % KEYPAD_ROWS]),
      .stable    (key_map[k]),
      .rise      (w_rise[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_valid   <= 1'b0;
      r_key_code    <= '0;
      r_key_overrun <= 1'b0;
    end else begin
      r_key_valid   <= |w_rise;
      r_key_overrun <= multi_hot(w_rise);
      if (|w_rise) r_key_code <= lowest_key(w_rise);
    end
  end

  assign key_valid   = r_key_valid;
  assign key_code    = r_key_code;
  assign key_overrun = r_key_overrun;

endmodule
`default_nettype wire
